// File: rtl/pit_channel_if.sv
// Bus-decode side of one PIT channel: program/latch strobes and count readback.
interface pit_channel_if #(
    parameter int unsigned CNT_W = 16
);
    logic             wr_i;
    logic [1:0]       mode_i;
    logic [CNT_W-1:0] load_i;
    logic             latch_i;
    logic [CNT_W-1:0] cnt_o;

    modport master (output wr_i, mode_i, load_i, latch_i, input cnt_o);
    modport slave  (input wr_i, mode_i, load_i, latch_i, output cnt_o);
endinterface

// File: rtl/pit_channel.sv
// 8254-style timer channel (modes 0, 2, 3) clocked by tick edges of tclk_i.
// Define PIT_LATCH_EN to build the count-latch holding register behind cnt_o.
module pit_channel #(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           tclk_i,
    input  logic           gate_i,
    pit_channel_if.slave   bus,
    output logic           out_o,
    output logic           irq_o
);
    localparam logic [1:0] MODE2 = 2'b01;
    localparam logic [1:0] MODE3 = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic [CNT_W-1:0] reload_eff, cnt_m1, cnt_step, step;
    logic [1:0]       mode_q, mode_d;
    logic             tclk_q, gate_q;
    logic             out_q, out_d, irq_q, irq_d, first_q, first_d;
    logic             tick, periodic, armed, gate_rise;

    assign tick       = tclk_i & ~tclk_q;
    assign periodic   = (mode_q == MODE2) || (mode_q == MODE3);
    assign armed      = (state_q != IDLE);
    assign gate_rise  = gate_i & ~gate_q & periodic & armed;
    assign reload_eff = (periodic && reload_q == CNT_W'(1)) ? CNT_W'(2) : reload_q;
    assign cnt_m1     = cnt_q - CNT_W'(1);
    assign cnt_step   = cnt_q - step;

    // Square wave: odd reloads shave one tick off the low phase via the first step.
    always_comb begin
        step = CNT_W'(2);
        if (first_q && reload_eff[0]) begin
            step = out_q ? CNT_W'(1) : CNT_W'(3);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.wr_i) begin
            state_d = LOAD;
        end else if (gate_rise) begin
            state_d = LOAD;
        end else if (state_q == LOAD && tick) begin
            state_d = COUNT;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        out_d    = out_q;
        irq_d    = 1'b0;
        first_d  = first_q;
        if (bus.wr_i) begin
            reload_d = bus.load_i;
            mode_d   = bus.mode_i;
            out_d    = (bus.mode_i == MODE2) || (bus.mode_i == MODE3);
        end else begin
            if (armed && periodic && !gate_i) begin
                out_d = 1'b1;
            end
            if (tick && !gate_rise) begin
                if (state_q == LOAD) begin
                    cnt_d   = reload_eff;
                    first_d = 1'b1;
                end else if (state_q == COUNT && gate_i) begin
                    case (mode_q)
                        MODE2: begin
                            if (cnt_q == CNT_W'(1)) begin
                                cnt_d = reload_eff;
                                out_d = 1'b1;
                                irq_d = 1'b1;
                            end else begin
                                cnt_d = cnt_m1;
                                if (cnt_m1 == CNT_W'(1)) begin
                                    out_d = 1'b0;
                                end
                            end
                        end
                        MODE3: begin
                            first_d = 1'b0;
                            if (cnt_step == '0) begin
                                cnt_d   = reload_eff;
                                out_d   = ~out_q;
                                irq_d   = out_q;
                                first_d = 1'b1;
                            end else begin
                                cnt_d = cnt_step;
                            end
                        end
                        default: begin
                            cnt_d = cnt_m1;
                            if (cnt_q == CNT_W'(1)) begin
                                out_d = 1'b1;
                                irq_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            reload_q <= '0;
            mode_q   <= '0;
            tclk_q   <= 1'b0;
            gate_q   <= 1'b0;
            out_q    <= 1'b0;
            irq_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tclk_q   <= tclk_i;
            gate_q   <= gate_i;
            out_q    <= out_d;
            irq_q    <= irq_d;
            first_q  <= first_d;
        end
    end

    assign out_o = out_q;
    assign irq_o = irq_q;

`ifdef PIT_LATCH_EN
    logic [CNT_W-1:0] latch_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latch_q <= '0;
        end else if (bus.latch_i) begin
            latch_q <= cnt_q;
        end
    end

    assign bus.cnt_o = latch_q;
`else
    logic unused_latch;
    assign unused_latch = bus.latch_i;
    assign bus.cnt_o    = cnt_q;
`endif
endmodule

// File: tb/tb_pit_channel.sv
// Directed bench for pit_channel: reset, modes 0/2/3, gating, write/tick collision, latch.
module tb_pit_channel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tclk = 1'b0;
    logic gate = 1'b1;
    logic out, irq;
    int checks = 0;
    int errors = 0;

    pit_channel_if #(.CNT_W(16)) bus ();

    pit_channel #(.CNT_W(16)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tclk_i (tclk),
        .gate_i (gate),
        .bus    (bus),
        .out_o  (out),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    logic [15:0] m2_cnt [8] = '{16'd3, 16'd2, 16'd1, 16'd4, 16'd3, 16'd2, 16'd1, 16'd4};
    logic        m2_out [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        m2_irq [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] m5_cnt [8] = '{16'd4, 16'd2, 16'd5, 16'd2, 16'd5, 16'd4, 16'd2, 16'd5};
    logic        m5_out [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        m5_irq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] m6_cnt [8] = '{16'd4, 16'd2, 16'd6, 16'd4, 16'd2, 16'd6, 16'd4, 16'd2};
    logic        m6_out [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        m6_irq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic state_chk(input string tag, input logic [15:0] c, input logic o, input logic i);
        chk({tag, ".cnt"}, 32'(bus.cnt_o), 32'(c));
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".irq"}, 32'(irq), 32'(i));
    endtask

    // One tclk rise; returns on the negedge after the tick cycle's update.
    task automatic do_tick();
        @(negedge clk) tclk = 1'b1;
        @(negedge clk) tclk = 1'b0;
    endtask

    task automatic do_wr(input logic [1:0] m, input logic [15:0] n);
        @(negedge clk);
        bus.wr_i = 1'b1; bus.mode_i = m; bus.load_i = n;
        @(negedge clk) bus.wr_i = 1'b0;
    endtask

    initial begin
        bus.wr_i = 1'b0; bus.mode_i = 2'b00; bus.load_i = '0; bus.latch_i = 1'b0;
        repeat (3) @(negedge clk);
        state_chk("reset", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) do_tick();
        state_chk("idle_ticks", 16'd0, 1'b0, 1'b0);

        // Mode 0, N=3
        do_wr(2'b00, 16'd3);
        state_chk("m0_wr", 16'd0, 1'b0, 1'b0);
        do_tick(); state_chk("m0_t1", 16'd3, 1'b0, 1'b0);
        do_tick(); state_chk("m0_t2", 16'd2, 1'b0, 1'b0);
        do_tick(); state_chk("m0_t3", 16'd1, 1'b0, 1'b0);
        do_tick(); state_chk("m0_t4", 16'd0, 1'b1, 1'b1);
        do_tick(); state_chk("m0_t5", 16'hFFFF, 1'b1, 1'b0);
        do_tick(); state_chk("m0_t6", 16'hFFFE, 1'b1, 1'b0);

        // Mode 0 gate pause
        do_wr(2'b00, 16'd10);
        repeat (3) do_tick();
        state_chk("m0g_pre", 16'd8, 1'b0, 1'b0);
        gate = 1'b0;
        repeat (5) do_tick();
        state_chk("m0g_frozen", 16'd8, 1'b0, 1'b0);
        gate = 1'b1;
        do_tick(); state_chk("m0g_resume", 16'd7, 1'b0, 1'b0);

        // Mode 2, N=4
        do_wr(2'b01, 16'd4);
        chk("m2_wr.out", 32'(out), 32'd1);
        do_tick(); state_chk("m2_load", 16'd4, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_tick(); state_chk($sformatf("m2n4_%0d", i), m2_cnt[i], m2_out[i], m2_irq[i]);
        end

        // Mode 2, N=1 coerced to period 2
        do_wr(2'b01, 16'd1);
        do_tick(); state_chk("m2n1_load", 16'd2, 1'b1, 1'b0);
        do_tick(); state_chk("m2n1_a", 16'd1, 1'b0, 1'b0);
        do_tick(); state_chk("m2n1_b", 16'd2, 1'b1, 1'b1);
        do_tick(); state_chk("m2n1_c", 16'd1, 1'b0, 1'b0);
        do_tick(); state_chk("m2n1_d", 16'd2, 1'b1, 1'b1);

        // Mode 3, N=5 (3 high / 2 low)
        do_wr(2'b10, 16'd5);
        do_tick(); state_chk("m3n5_load", 16'd5, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_tick(); state_chk($sformatf("m3n5_%0d", i), m5_cnt[i], m5_out[i], m5_irq[i]);
        end

        // Mode 3, N=6 (3 high / 3 low)
        do_wr(2'b10, 16'd6);
        do_tick(); state_chk("m3n6_load", 16'd6, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_tick(); state_chk($sformatf("m3n6_%0d", i), m6_cnt[i], m6_out[i], m6_irq[i]);
        end

        // Mode 3 gate low holds out high; gate rise reloads N
        gate = 1'b0;
        @(negedge clk);
        chk("m3g_out", 32'(out), 32'd1);
        repeat (2) do_tick();
        state_chk("m3g_frozen", 16'd2, 1'b1, 1'b0);
        gate = 1'b1;
        do_tick(); state_chk("m3g_reload", 16'd6, 1'b1, 1'b0);
        do_tick(); state_chk("m3g_next", 16'd4, 1'b1, 1'b0);

        // Write coincident with a tick: tick ignored
        do_wr(2'b01, 16'd4);
        do_tick(); do_tick();
        state_chk("wrt_pre", 16'd3, 1'b1, 1'b0);
        @(negedge clk);
        bus.wr_i = 1'b1; bus.mode_i = 2'b01; bus.load_i = 16'd9; tclk = 1'b1;
        @(negedge clk);
        bus.wr_i = 1'b0; tclk = 1'b0;
        state_chk("wrt_same", 16'd3, 1'b1, 1'b0);
        do_tick(); state_chk("wrt_load", 16'd9, 1'b1, 1'b0);

        // Latch on a tick with cnt=7
        do_wr(2'b00, 16'd9);
        repeat (3) do_tick();
        chk("lat_pre", 32'(bus.cnt_o), 32'd7);
        @(negedge clk);
        bus.latch_i = 1'b1; tclk = 1'b1;
        @(negedge clk);
        bus.latch_i = 1'b0; tclk = 1'b0;
`ifdef PIT_LATCH_EN
        chk("lat_hold", 32'(bus.cnt_o), 32'd7);
        do_tick(); chk("lat_hold2", 32'(bus.cnt_o), 32'd7);
`else
        chk("lat_live", 32'(bus.cnt_o), 32'd6);
        do_tick(); chk("lat_live2", 32'(bus.cnt_o), 32'd5);
`endif

        // Reset mid-count in mode 2, N=10
        do_wr(2'b01, 16'd10);
        do_tick(); do_tick();
        state_chk("rst_pre", 16'd9, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        state_chk("rst_async", 16'd0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (3) do_tick();
        state_chk("rst_idle", 16'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
